axis_master_packetizer: RTL
===========================

Name: axis_master_packetizer

Overview:
- Parametrised next-generation AXI-Stream master source.
- Accepts beats from a local write port into an internal FIFO and drives a fully AXI-Stream-compliant master channel: tvalid held until handshake, byte-granular tkeep/tstrb and configurable TID/TDEST/TUSER.
- Enforces a maximum packet length by forcing tlast, and reports FIFO fill level and completed-packet events.
- Sits between a data-producing engine or testbench driver and any AXIS slave.

Parameters:
N_BYTES, 4, tdata width in bytes (tdata = 8*N_BYTES bits), >=1
DEPTH, 8, FIFO depth in beats, power of two, >=2
MAX_BEATS, 16, maximum beats per packet; tlast forced on beat MAX_BEATS, >=1
ID_W, 1, width of tid
DEST_W, 1, width of tdest
USER_W, 1, width of tuser

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-high reset
wr_valid  in  1  write-side beat offered
wr_ready  out  1  write-side can accept (FIFO not full)
wr_data  in  8*N_BYTES  beat data, byte 0 in bits [7:0]
wr_bytes  in  $clog2(N_BYTES)+1  valid byte count, low-justified, 0..N_BYTES
wr_last  in  1  beat ends packet
wr_user  in  USER_W  per-beat sideband
cfg_id  in  ID_W  stream ID, sampled per beat at write
cfg_dest  in  DEST_W  destination, sampled per beat at write
tvalid  out  1  AXIS valid
tready  in  1  AXIS ready
tdata  out  8*N_BYTES  AXIS data
tstrb  out  N_BYTES  AXIS byte strobe
tkeep  out  N_BYTES  AXIS byte keep
tlast  out  1  AXIS packet end
tid  out  ID_W  AXIS ID
tdest  out  DEST_W  AXIS destination
tuser  out  USER_W  AXIS user
fill_level  out  $clog2(DEPTH)+1  beats currently stored, 0..DEPTH
pkt_done  out  1  one-cycle pulse after a tlast handshake
pkt_count  out  16  completed packets, wraps 0xFFFF->0

Behaviour:
- Reset (areset high, asynchronous):
  - All outputs 0 except wr_ready=1.
  - FIFO emptied; write beat counter, pkt_count and pkt_done cleared.
  - Asserting reset mid-packet discards all stored beats. No partial tlast is emitted.
- Write accept:
  - Beat is pushed when wr_valid && wr_ready.
  - wr_ready = (fill_level != DEPTH), combinational from registered state.
- Per-beat storage:
  - Fields stored: data, keep, last_eff, user, id, dest.
  - keep = (1<<wr_bytes)-1; wr_bytes > N_BYTES saturates to all ones; wr_bytes = 0 stores a null beat (keep = 0).
  - tstrb equals tkeep for every beat.
- Packet-length enforcement:
  - Write beat counter wcnt counts pushed beats in the current packet.
  - last_eff = wr_last || (wcnt == MAX_BEATS-1).
  - wcnt returns to 0 after pushing a last_eff beat, otherwise increments.
  - MAX_BEATS = 1 makes every beat last.
- Output:
  - First-word fall-through: tvalid = (fill_level != 0).
  - tdata, tkeep, tstrb, tlast, tid, tdest, tuser always show the FIFO head.
  - Latency: a beat pushed at edge k is visible with tvalid=1 after edge k when the FIFO was empty.
  - Pop on tvalid && tready.
  - While tvalid=1 and tready=0, all AXIS outputs stay stable (AXIS rule). They never change without a handshake.
- Simultaneous push and pop:
  - fill_level unchanged; head advances.
  - Allowed at any fill level below DEPTH. When full, push is blocked and pop proceeds.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - fill_level is tracked by a separate counter.
  - No overflow is possible. Empty reads never occur because pop requires tvalid.
- Completion reporting:
  - pkt_done = registered (tvalid && tready && tlast): high the cycle after the last-beat handshake, for one cycle.
  - pkt_count increments on the same edge pkt_done rises.
  - Back-to-back single-beat packets pulse pkt_done on consecutive cycles.
- cfg_id/cfg_dest changes affect only subsequently pushed beats. They do not affect beats already stored.

Test Plan:
- Reset, then push 3 beats (data 0x11111111, 0x22222222, 0x33333333; wr_bytes=4; last on beat 3) with tready=1 -> tvalid rises one cycle after the first push; 3 handshakes in order; tkeep=tstrb=0xF; tlast on beat 3 only; pkt_done pulse; pkt_count=1.
- tready=0, push 8 beats -> fill_level=8, wr_ready=0; 9th wr_valid ignored; head outputs stable throughout; raise tready -> 8 beats drain in order, fill_level reaches 0, tvalid=0.
- Push beats with wr_bytes=1,2,3,0,7 -> tkeep=0x1, 0x3, 0x7, 0x0, 0xF respectively; tstrb identical.
- MAX_BEATS=16, push 20 beats with wr_last only on beat 20 -> tlast on beat 16 and beat 20; pkt_count=2.
- Full FIFO with tready=1 and wr_valid=1 for 10 cycles -> steady one-in-one-out, fill_level stays DEPTH-1 or DEPTH per rules; no beat lost or duplicated (scoreboard).
- Assert areset mid-packet with fill_level=5 -> tvalid=0, fill_level=0 immediately; after release, a new 2-beat packet emits cleanly; pkt_count=0 then 1.

Source files
------------

// File: rtl/axis_master_packetizer.sv
// AXI-Stream master source: local write port -> first-word fall-through FIFO -> AXIS master.
// Forces tlast every MAX_BEATS beats and reports fill level and completed packets.
module axis_master_packetizer #(
  parameter int N_BYTES   = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = 1,
  parameter int DEST_W    = 1,
  parameter int USER_W    = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [8*N_BYTES-1:0]         wr_data,
  input  logic [$clog2(N_BYTES):0]     wr_bytes,
  input  logic                         wr_last,
  input  logic [USER_W-1:0]            wr_user,
  input  logic [ID_W-1:0]              cfg_id,
  input  logic [DEST_W-1:0]            cfg_dest,
  output logic                         tvalid,
  input  logic                         tready,
  output logic [8*N_BYTES-1:0]         tdata,
  output logic [N_BYTES-1:0]           tstrb,
  output logic [N_BYTES-1:0]           tkeep,
  output logic                         tlast,
  output logic [ID_W-1:0]              tid,
  output logic [DEST_W-1:0]            tdest,
  output logic [USER_W-1:0]            tuser,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         pkt_done,
  output logic [15:0]                  pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(MAX_BEATS) + 1;

  logic [8*N_BYTES-1:0] r_mem_data [DEPTH];
  logic [N_BYTES-1:0]   r_mem_keep [DEPTH];
  logic                 r_mem_last [DEPTH];
  logic [USER_W-1:0]    r_mem_user [DEPTH];
  logic [ID_W-1:0]      r_mem_id   [DEPTH];
  logic [DEST_W-1:0]    r_mem_dest [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_wcnt;
  logic          r_pkt_done;
  logic [15:0]   r_pkt_count;

  logic [N_BYTES-1:0] w_keep;
  logic               w_last_eff;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;

  // Low-justified keep mask; counts above N_BYTES naturally saturate to all ones.
  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_keep
      assign w_keep[gi] = (int'(wr_bytes) > gi);
    end
  endgenerate

  assign w_empty    = (r_fill == '0);
  assign w_full     = (r_fill == FW'(DEPTH));
  assign w_push     = wr_valid && !w_full;
  assign w_pop      = !w_empty && tready;
  assign w_last_eff = wr_last || (r_wcnt == CW'(MAX_BEATS - 1));

  assign wr_ready   = !w_full;
  assign tvalid     = !w_empty;
  assign fill_level = r_fill;
  assign pkt_done   = r_pkt_done;
  assign pkt_count  = r_pkt_count;

  // Head fields are masked while empty so stale entries never leak after a reset.
  assign tdata = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign tkeep = w_empty ? '0 : r_mem_keep[r_rd_ptr];
  assign tstrb = tkeep;
  assign tlast = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
  assign tid   = w_empty ? '0 : r_mem_id[r_rd_ptr];
  assign tdest = w_empty ? '0 : r_mem_dest[r_rd_ptr];
  assign tuser = w_empty ? '0 : r_mem_user[r_rd_ptr];

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= wr_data;
      r_mem_keep[r_wr_ptr] <= w_keep;
      r_mem_last[r_wr_ptr] <= w_last_eff;
      r_mem_user[r_wr_ptr] <= wr_user;
      r_mem_id[r_wr_ptr]   <= cfg_id;
      r_mem_dest[r_wr_ptr] <= cfg_dest;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_wcnt      <= '0;
      r_pkt_done  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_wcnt   <= w_last_eff ? '0 : r_wcnt + CW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
      r_pkt_done <= w_pop && tlast;
      if (w_pop && tlast) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

endmodule
